algo_t1_sram_resp: RTL

ALGO_T1_SRAM_RESP -- requirements
Module: algo_t1_sram_resp

---
 rtl/algo_t1_pkg.sv | 14 +
 rtl/algo_t1_rd_pipe.sv | 52 +++++
 rtl/algo_t1_sram_resp.sv | 114 +++++++++++
 3 files changed

// File: rtl/algo_t1_pkg.sv
// rtl/algo_t1_pkg.sv - shared state encoding and constants for the T1 SRAM responder
// Purpose: controller state enumeration and the latency ceiling of the read delay line.
// Ports: none (package).
package algo_t1_pkg;

   typedef enum logic [1:0] {
      RST  = 2'd0,
      INIT = 2'd1,
      RDY  = 2'd2
   } state_t;

   localparam int MAX_SRAM_DELAY = 4;

endpackage

// File: rtl/algo_t1_rd_pipe.sv
// rtl/algo_t1_rd_pipe.sv - read-latency delay line for valid and data
// Purpose: delays a read-valid/data pair by DELAY cycles; synchronous active-low clear.
// Ports:
//   clk      - clock
//   rst      - synchronous active-low clear of all stages
//   vld      - read accepted this cycle
//   data     - row data captured for that read
//   dly_vld  - vld delayed by DELAY cycles
//   dly_data - data of the most recent delivered read (holds between reads)
module algo_t1_rd_pipe
   import algo_t1_pkg::*;
#(
   parameter int W     = 128,
   parameter int DELAY = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         vld,
   input  logic [W-1:0] data,
   output logic         dly_vld,
   output logic [W-1:0] dly_data
);

   logic [DELAY-1:0] vld_q;
   logic [W-1:0]     data_q [DELAY];

   // A data stage only loads when a valid read moves into it, so the final
   // stage keeps the last delivered read data while no read is arriving.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q <= '0;
         for (int i = 0; i < DELAY; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= vld;
         if (vld) begin
            data_q[0] <= data;
         end
         for (int i = 1; i < DELAY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               data_q[i] <= data_q[i-1];
            end
         end
      end
   end

   assign dly_vld  = vld_q[DELAY-1];
   assign dly_data = data_q[DELAY-1];

endmodule

// File: rtl/algo_t1_sram_resp.sv
// rtl/algo_t1_sram_resp.sv - behavioural SRAM responder with init sweep and pipelined reads
// Purpose: row array with bit-masked write port A, latency-delayed read port B,
//          post-reset zero-fill of every row and out-of-range command reporting.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   t1_writeA/addrA/dinA/bwA - masked row write
//   t1_readB/addrB      - row read request
//   t1_doutB/t1_vldB    - read data and valid, SRAM_DELAY cycles after request
//   ready               - array initialised, commands accepted
//   oor_err             - one-cycle pulse for an accepted command beyond the last row
module algo_t1_sram_resp
   import algo_t1_pkg::*;
#(
   parameter int PHYWDTH    = 128,
   parameter int NUMSROW    = 4096,
   parameter int BITSROW    = 12,
   parameter int SRAM_DELAY = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               t1_writeA,
   input  logic [BITSROW-1:0] t1_addrA,
   input  logic [PHYWDTH-1:0] t1_dinA,
   input  logic [PHYWDTH-1:0] t1_bwA,
   input  logic               t1_readB,
   input  logic [BITSROW-1:0] t1_addrB,
   output logic [PHYWDTH-1:0] t1_doutB,
   output logic               t1_vldB,
   output logic               ready,
   output logic               oor_err
);

   localparam int DLY = (SRAM_DELAY > MAX_SRAM_DELAY) ? MAX_SRAM_DELAY :
                        (SRAM_DELAY < 1) ? 1 : SRAM_DELAY;
   localparam logic [BITSROW:0]   NUM_ROWS = (BITSROW+1)'(NUMSROW);
   localparam logic [BITSROW-1:0] LAST_ROW = BITSROW'(NUMSROW - 1);

   state_t             state;
   logic [BITSROW-1:0] cnt;
   logic [PHYWDTH-1:0] mem [NUMSROW];
   logic               oor_a;
   logic               oor_b;
   logic               rd_acc;
   logic [PHYWDTH-1:0] rd_data;

   assign oor_a  = ({1'b0, t1_addrA} >= NUM_ROWS);
   assign oor_b  = ({1'b0, t1_addrB} >= NUM_ROWS);
   assign rd_acc = (state == RDY) && t1_readB;

   // Array read happens before this edge's write lands, so a same-cycle
   // read of the written row sees the old contents.
   always_comb begin
      rd_data = '0;
      if (!oor_b) begin
         rd_data = mem[t1_addrB];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= RST;
         cnt     <= '0;
         ready   <= 1'b0;
         oor_err <= 1'b0;
      end else begin
         oor_err <= 1'b0;
         case (state)
            RST: begin
               state <= INIT;
               cnt   <= '0;
            end
            INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST_ROW) begin
                  state <= RDY;
                  ready <= 1'b1;
                  cnt   <= '0;
               end
            end
            RDY: begin
               // A and B errors in the same cycle collapse into one pulse.
               oor_err <= (t1_writeA && oor_a) || (t1_readB && oor_b);
            end
            default: begin
               state <= RST;
               ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if (state == INIT) begin
            mem[cnt] <= '0;
         end else if (state == RDY && t1_writeA && !oor_a) begin
            mem[t1_addrA] <= (mem[t1_addrA] & ~t1_bwA) | (t1_dinA & t1_bwA);
         end
      end
   end

   algo_t1_rd_pipe #(
      .W     (PHYWDTH),
      .DELAY (DLY)
   ) u_rd_pipe (
      .clk      (clk),
      .rst      (rst),
      .vld      (rd_acc),
      .data     (rd_data),
      .dly_vld  (t1_vldB),
      .dly_data (t1_doutB)
   );

endmodule
